// File: rtl/vasim_chain_matcher.sv
// Linear chain of PATTERN_LEN STEs recognising a fixed byte string, with a one-entry
// report buffer (valid/ready), saturating match counter and sticky overflow flag.
module vasim_chain_matcher #(
   parameter int unsigned                PATTERN_LEN = 3,
   // Character i sits in bits [8i+7:8i] and i=0 is matched first, so "SRC" packs as C,R,S.
   parameter logic [8*PATTERN_LEN-1:0]   PATTERN     = {8'h43, 8'h52, 8'h53},
   parameter bit                         CASE_FOLD   = 1'b1,
   parameter int unsigned                START_MODE  = 2,
   parameter int unsigned                OFFSET_W    = 32,
   parameter int unsigned                CNT_W       = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                run_i,
   input  logic [7:0]          symbols_i,
   output logic                match_out_o,
   output logic                report_valid_o,
   input  logic                report_ready_i,
   output logic [OFFSET_W-1:0] report_offset_o,
   output logic [CNT_W-1:0]    report_count_o,
   output logic                report_overflow_o
);

   localparam bit AllInput = (START_MODE == 2);

   function automatic logic is_letter(input logic [7:0] c);
      return ((c >= 8'h41) && (c <= 8'h5a)) || ((c >= 8'h61) && (c <= 8'h7a));
   endfunction

   function automatic logic char_match(input logic [7:0] a, input logic [7:0] b);
      if (CASE_FOLD && is_letter(a) && is_letter(b)) begin
         return (a & 8'hdf) == (b & 8'hdf);
      end
      return a == b;
   endfunction

   logic [PATTERN_LEN-1:0] char_hit;
   logic [PATTERN_LEN-1:0] ste_q, ste_d;
   logic                   first_q, first_d;
   logic [OFFSET_W-1:0]    off_q, off_d;
   logic                   en0;
   logic                   hit;

   logic                   valid_q, valid_d;
   logic [OFFSET_W-1:0]    offset_q, offset_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   ovf_q, ovf_d;

   always_comb begin
      char_hit = '0;
      for (int unsigned i = 0; i < PATTERN_LEN; i++) begin
         char_hit[i] = char_match(symbols_i, PATTERN[8*i +: 8]);
      end
   end

   assign en0 = AllInput | first_q;

   // Chain advance: every STE shifts at once, and only on run cycles.
   always_comb begin
      ste_d   = ste_q;
      first_d = first_q;
      off_d   = off_q;
      if (run_i) begin
         ste_d[0] = en0 & char_hit[0];
         for (int unsigned i = 1; i < PATTERN_LEN; i++) begin
            ste_d[i] = ste_q[i-1] & char_hit[i];
         end
         first_d = 1'b0;
         off_d   = off_q + OFFSET_W'(1);
      end
   end

   assign hit = run_i & ste_d[PATTERN_LEN-1];

   always_comb begin
      valid_d  = valid_q;
      offset_d = offset_q;
      ovf_d    = ovf_q;
      cnt_d    = cnt_q;
      if (hit) begin
         if (!valid_q || report_ready_i) begin
            valid_d  = 1'b1;
            offset_d = off_q;
         end else begin
            // Buffer still occupied and not being drained: keep the old report.
            ovf_d = 1'b1;
         end
         if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (valid_q && report_ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ste_q    <= '0;
         first_q  <= 1'b1;
         off_q    <= '0;
         valid_q  <= 1'b0;
         offset_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         ste_q    <= ste_d;
         first_q  <= first_d;
         off_q    <= off_d;
         valid_q  <= valid_d;
         offset_q <= offset_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
      end
   end

   assign match_out_o       = ste_q[PATTERN_LEN-1];
   assign report_valid_o    = valid_q;
   assign report_offset_o   = offset_q;
   assign report_count_o    = cnt_q;
   assign report_overflow_o = ovf_q;

endmodule

// File: doc/vasim_chain_matcher.md
# vasim_chain_matcher

Parametrised linear-chain automaton: a run-gated chain of `PATTERN_LEN` STEs that recognises a fixed byte string in the symbol stream, with optional ASCII case folding and a selectable start mode. Beyond the per-cycle match pulse, the block records the stream offset of each completed match in a one-entry report buffer with a valid/ready handshake, a saturating match counter and a sticky overflow flag. It sits between the symbol broadcast and the kernel's report collection logic, in place of the generated fixed-length three-STE chains.

## Interface
- `PATTERN_LEN`, 3: number of chained STEs, ≥1.
- `PATTERN`, "SRC": packed `8*PATTERN_LEN` bits; character i occupies bits [8i+7:8i]; i=0 is matched first.
- `CASE_FOLD`, 1: 1 = letters A–Z/a–z match either case; 0 = exact byte compare.
- `START_MODE`, 2: 1 = start-of-data (STE 0 enabled on first run cycle only); 2 = all-input (STE 0 enabled every run cycle).
- `OFFSET_W`, 32: width of symbol offset counter.
- `CNT_W`, 16: width of match counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `run` in 1: symbol valid; all state advances only when 1.
- `symbols` in 8: current symbol.
- `match_out` out 1: final-STE active state.
- `report_valid` out 1: report buffer holds an unconsumed match.
- `report_ready` in 1: consumer accepts the report this cycle.
- `report_offset` out OFFSET_W: offset of the symbol that completed the buffered match.
- `report_count` out CNT_W: matches seen since reset, saturating.
- `report_overflow` out 1: sticky; a match was dropped.

## Operation
- Offset counter `off`: reset 0; +1 on each `run` cycle; wraps modulo 2^OFFSET_W.
- Char compare m[i]: `symbols == PATTERN[i]`; with CASE_FOLD=1, both sides with bit 5 cleared when either is a letter (0x41–0x5A, 0x61–0x7A) and both letters; non-letters exact.
- STE state s[i], reset 0. On a `run` edge: s[0] ← en0 & m[0]; s[i] ← s[i-1] & m[i] for i>0. On `run`=0, all s[] hold.
- en0: START_MODE=2 → 1. START_MODE=1 → `first` flag; `first` set on reset, cleared on first `run` edge.
- `match_out` = s[PATTERN_LEN-1].
- hit = next-state of s[PATTERN_LEN-1] on a `run` edge.
- Report buffer, on each edge:
  - hit & (!report_valid | report_ready): load `off` (pre-increment value), valid ← 1.
  - hit & report_valid & !report_ready: drop the new report; overflow ← 1; the buffered report is unchanged.
  - !hit & report_valid & report_ready: valid ← 0.
- `report_count` += 1 on every hit (including dropped), saturating at 2^CNT_W−1.
- `report_overflow` clears only on reset.
- PATTERN_LEN=1 is legal: s[0] is also the final STE.

## Timing
- Reset (async assert, sync-safe deassert): all s[], `match_out`, `report_valid`, `report_offset`, `report_count`, `report_overflow` = 0; `first` = 1; `off` = 0.
- Latency: the last pattern symbol is sampled at edge t. `match_out` and `report_valid` are high from t to t+1. `match_out` stays high for exactly one run cycle per hit, and holds while `run`=0.
- `report_ready` is ignored while `report_valid`=0. A consumed report drops `report_valid` at the next edge unless that edge also loads a new report.
- Overlapping matches (e.g. PATTERN "AA", input "AAA") produce back-to-back hits, one per edge.
- Reset mid-match discards partial chains and any buffered report.

## Test plan
- Default parameters; `run`=1; input "xsRcSRC" (offsets 0–6); `report_ready`=1 → `match_out` pulses after offsets 3 and 6; reports 3 then 6; `report_count`=2; overflow 0.
- CASE_FOLD=0, same input → single report offset 6; "src" produces no hit.
- START_MODE=1, input "SRCSRC" → single report offset 2; `report_count`=1.
- `report_ready`=0, input "SRCSRC" → report 2 held; second hit dropped; `report_overflow`=1; `report_count`=2. Raise ready → valid drops next edge.
- `run` deasserted for 5 cycles between 'R' and 'C' of "SRC" → states hold; hit on 'C'; offset 2; `off` does not advance during the gap.
- PATTERN_LEN=2, PATTERN "AA", input "AAAA" → reports 1,2,3 with `report_ready`=1. Assert `reset` low mid-stream → all outputs 0 immediately; a subsequent "AA" reports offset 1.
